audio_src_arbiter: RTL and testbench
====================================

// Module: audio_src_arbiter
// PURPOSE
//  Shares the single speaker serializer between N_REQ tone requesters (e.g. melody player, key beep, alarm).
//  - Grants one requester at a time under fixed priority (index 0 highest).
//  - Synthesizes a signed 16-bit square wave from the owner's half-period divider.
//  - Drives audio_left/audio_right into the speaker serializer.
//  - Inserts a silent gap on every change of owner to avoid clicks.
// PARAMETERS
//  N_REQ    3        number of requesters
//  DIV_W    22       width of each half-period divider (cycles of clk)
//  AMP      16'h2000 square-wave amplitude; output is +AMP / -AMP, two's complement
//  GAP_CYC  16       silent cycles between owners; must be >= 1
// PORTS
//  clk        in   1            system clock (100 MHz)
//  rst_n      in   1            asynchronous reset, active low
//  req        in   N_REQ        level request; held high for as long as the source wants the speaker
//  note_div   in   N_REQ*DIV_W  packed half-period per requester; slice i = [i*DIV_W +: DIV_W]
//  mute       in   1            forces the sample to 0; arbitration continues
//  gnt        out  N_REQ        one-hot owner, registered; all-zero when no owner
//  busy       out  1            high in PLAY and GAP
//  audio_left out  16           sample to the speaker serializer
//  audio_right out 16           identical to audio_left
// BEHAVIOUR
//  Reset: state=IDLE, gnt=0, busy=0, audio_left=audio_right=0, counter=0, phase=0.
//  States:
//  - IDLE: any req -> PLAY next cycle. gnt = highest-priority asserted req, counter=0, phase=1.
//  - PLAY:
//    - owner req falls -> GAP.
//    - a higher-priority req rises -> GAP (pre-emption). gnt clears on entry to GAP.
//    - lower-priority reqs are ignored while an owner plays.
//  - GAP: counts GAP_CYC cycles with the sample at 0.
//    - At the end: pick the highest-priority req asserted in that cycle -> PLAY; none -> IDLE.
//    - Req changes during GAP only matter in the final cycle.
//  Square wave (PLAY only):
//  - Half-period counter runs 0..div-1. At div-1 it wraps to 0 and phase toggles.
//  - sample = phase ? +AMP : -AMP.
//  - Latency: first +AMP sample in the same cycle gnt rises (one cycle after req). First toggle after div cycles.
//  - div is loaded from the owner's slice at grant and reloaded at every wrap. A mid-period change takes effect at the next wrap.
//  - div==0: sample=0, counter held at 0. div==1: toggles every cycle.
//  Output registers: audio_left/right are registered. They are 0 in IDLE, in GAP, or when mute=1.
//  busy: 1 exactly when state is PLAY or GAP.
//  Simultaneous events:
//  - Owner drop and higher-priority rise in the same cycle -> one GAP.
//  - Req rising in the same cycle IDLE is left -> included in the priority pick.
//  Reset mid-operation: all outputs go to their reset values immediately (async). The next grant restarts the wave at phase=1.
// STRUCTURE
//  Package audio_pkg:
//  - state enum {IDLE, PLAY, GAP}.
//  - Defaults for AMP and GAP_CYC.
//  - Function prio_pick(req) returning one-hot.
//  Sub-module square_wave_gen: counter, phase, div reload, div==0 handling, AMP select.
//  - Ports: clk, rst_n, start, div, sample.
//  Top holds the arbiter FSM, gap counter, mute and output registers.
// TESTING
//  (N_REQ=3, GAP_CYC=4, AMP=16'h2000)
//  1. req=001, div0=5:
//     - gnt=001 and sample=16'h2000 one cycle after req.
//     - 16'hE000 after 5 cycles; period 10.
//  2. Owner 2 playing, req0 rises:
//     - gnt=000 and sample=0 for 4 cycles.
//     - Then gnt=001 and the wave restarts at +AMP.
//  3. req=011 steady, req0 falls: 4-cycle gap, then gnt=010. With all reqs low after the gap -> IDLE, busy=0.
//  4. div0 changes 5->3 mid-period: the current half-period stays 5 cycles, the next is 3. div0=0 -> sample 0 held.
//  5. mute=1 during PLAY: sample=0 but gnt and phase keep advancing. mute=0 -> output resumes at the correct phase.
//  6. rst_n low mid-PLAY (async, between edges): all outputs 0 at once. After release with req=100 -> gnt=100 with +AMP first.

Source files
------------

// File: rtl/audio_src_arbiter_pkg.sv
// Shared types and helpers for the speaker source arbiter.
package audio_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [15:0] AMP_DEFAULT     = 16'h2000;
    localparam int          GAP_CYC_DEFAULT = 16;

    // Widest request vector the priority helper handles; callers cast down.
    localparam int          MAX_REQ         = 32;

    // Isolates the lowest set bit, so index 0 always wins.
    function automatic logic [MAX_REQ-1:0] prio_pick(input logic [MAX_REQ-1:0] r);
        return r & (~r + {{(MAX_REQ-1){1'b0}}, 1'b1});
    endfunction

endpackage

// File: rtl/audio_src_arbiter_square_wave_gen.sv
// Square-wave synthesizer: half-period counter, phase bit and divider reload.
// The sample port is the value the wave holds after the coming clock edge,
// so the owner can register it in step with its own grant.
module square_wave_gen
    import audio_pkg::*;
#(
    parameter int          DIV_W = 22,
    parameter logic [15:0] AMP   = AMP_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DIV_W-1:0] div,
    output logic [15:0]      sample
);

    localparam logic [15:0] NEG_AMP = ~AMP + 16'd1;

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             phase_q, phase_d;

    // Next-state for counter, phase and latched divider; a zero divider
    // parks the counter and keeps sampling the input so a new value is seen.
    always_comb begin
        cnt_d   = cnt_q;
        div_d   = div_q;
        phase_d = phase_q;
        if (start) begin
            cnt_d   = '0;
            phase_d = 1'b1;
            div_d   = div;
        end else if (div_q == '0) begin
            cnt_d = '0;
            div_d = div;
        end else if (cnt_q == div_q - DIV_W'(1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
            div_d   = div;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    // Lookahead sample: silent for a zero divider, otherwise +/- amplitude.
    always_comb begin
        sample = '0;
        if (div_d != '0) begin
            sample = phase_d ? AMP : NEG_AMP;
        end
    end

    // Wave state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            div_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/audio_src_arbiter.sv
// Fixed-priority owner of the speaker serializer with a silent gap between
// owners. Index 0 is the highest priority requester.
module audio_src_arbiter
    import audio_pkg::*;
#(
    parameter int          N_REQ   = 3,
    parameter int          DIV_W   = 22,
    parameter logic [15:0] AMP     = AMP_DEFAULT,
    parameter int          GAP_CYC = GAP_CYC_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*DIV_W-1:0] note_div,
    input  logic                   mute,
    output logic [N_REQ-1:0]       gnt,
    output logic                   busy,
    output logic [15:0]            audio_left,
    output logic [15:0]            audio_right
);

    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    state_t           state_q;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [GW-1:0]    gap_q;
    logic [15:0]      audio_q, audio_d;

    logic [N_REQ-1:0] pick;
    logic             gap_last;
    logic             start;
    logic             leave;
    logic             play_d;
    logic [DIV_W-1:0] div_sel;
    logic [15:0]      wave_sample;

    assign pick     = N_REQ'(prio_pick(MAX_REQ'(req)));
    assign gap_last = (gap_q == GW'(GAP_CYC - 1));

    // Decode grant/leave events; gnt_q minus one masks the higher-priority
    // indices, so an owner drop and a pre-emption collapse into one leave.
    always_comb begin
        start  = (|req) && ((state_q == IDLE) || ((state_q == GAP) && gap_last));
        leave  = (state_q == PLAY) &&
                 (((req & gnt_q) == '0) || ((req & (gnt_q - N_REQ'(1))) != '0));
        play_d = start || ((state_q == PLAY) && !leave);
        gnt_d  = '0;
        if (start) begin
            gnt_d = pick;
        end else if (play_d) begin
            gnt_d = gnt_q;
        end
    end

    // Divider of the owner as it will be after this edge, so a new grant
    // loads its own half-period.
    always_comb begin
        div_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_d[i]) begin
                div_sel = div_sel | note_div[i*DIV_W +: DIV_W];
            end
        end
    end

    square_wave_gen #(
        .DIV_W (DIV_W),
        .AMP   (AMP)
    ) u_wave (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .div    (div_sel),
        .sample (wave_sample)
    );

    assign audio_d = (play_d && !mute) ? wave_sample : 16'd0;

    // Arbiter FSM with gap counter and registered grant and sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            gap_q   <= '0;
            audio_q <= '0;
        end else begin
            gnt_q   <= gnt_d;
            audio_q <= audio_d;
            case (state_q)
                IDLE: begin
                    if (start) state_q <= PLAY;
                end
                PLAY: begin
                    if (leave) begin
                        state_q <= GAP;
                        gap_q   <= '0;
                    end
                end
                GAP: begin
                    if (gap_last) begin
                        state_q <= start ? PLAY : IDLE;
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt         = gnt_q;
    assign busy        = (state_q != IDLE);
    assign audio_left  = audio_q;
    assign audio_right = audio_q;

endmodule

// File: tb/tb_audio_src_arbiter.sv
// Directed bench for audio_src_arbiter with N_REQ=3, GAP_CYC=4, AMP=16'h2000.
module tb_audio_src_arbiter;

    localparam int N_REQ = 3;
    localparam int DIV_W = 22;
    localparam logic [15:0] POS = 16'h2000;
    localparam logic [15:0] NEG = 16'hE000;

    logic                   clk;
    logic                   rst_n;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*DIV_W-1:0] note_div;
    logic                   mute;
    logic [N_REQ-1:0]       gnt;
    logic                   busy;
    logic [15:0]            audio_left;
    logic [15:0]            audio_right;

    int total;
    int bad;

    audio_src_arbiter #(
        .N_REQ   (N_REQ),
        .DIV_W   (DIV_W),
        .AMP     (16'h2000),
        .GAP_CYC (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .note_div    (note_div),
        .mute        (mute),
        .gnt         (gnt),
        .busy        (busy),
        .audio_left  (audio_left),
        .audio_right (audio_right)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic waitCycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [N_REQ-1:0] r);
        req = r;
    endtask

    task automatic setDiv(input int idx, input logic [DIV_W-1:0] v);
        note_div[idx*DIV_W +: DIV_W] = v;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Directed sequence covering reset, wave timing, gaps, mute and async reset.
    initial begin
        total    = 0;
        bad      = 0;
        req      = '0;
        note_div = '0;
        mute     = 1'b0;
        rst_n    = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_gnt",   16'(gnt), 16'h0);
        checkOutput("rst_busy",  16'(busy), 16'h0);
        checkOutput("rst_left",  audio_left, 16'h0);
        checkOutput("rst_right", audio_right, 16'h0);
        waitCycles(2);
        rst_n = 1'b1;
        waitCycles(1);
        checkOutput("idle_gnt", 16'(gnt), 16'h0);

        $display("[TB] single owner, div=5");
        setDiv(0, 22'd5);
        applyStimulus(3'b001);
        waitCycles(1);
        checkOutput("t1_gnt",   16'(gnt), 16'h1);
        checkOutput("t1_first", audio_left, POS);
        checkOutput("t1_right", audio_right, POS);
        checkOutput("t1_busy",  16'(busy), 16'h1);
        waitCycles(4);
        checkOutput("t1_hold",  audio_left, POS);
        waitCycles(1);
        checkOutput("t1_low",   audio_left, NEG);
        waitCycles(4);
        checkOutput("t1_lowend", audio_left, NEG);
        waitCycles(1);
        checkOutput("t1_period", audio_left, POS);

        $display("[TB] divider change mid-period");
        waitCycles(2);
        setDiv(0, 22'd3);
        waitCycles(2);
        checkOutput("t4_old_hold", audio_left, POS);
        waitCycles(1);
        checkOutput("t4_old_wrap", audio_left, NEG);
        waitCycles(2);
        checkOutput("t4_new_hold", audio_left, NEG);
        waitCycles(1);
        checkOutput("t4_new_wrap", audio_left, POS);
        setDiv(0, 22'd0);
        waitCycles(2);
        checkOutput("t4_z_hold", audio_left, POS);
        waitCycles(1);
        checkOutput("t4_zero", audio_left, 16'h0);
        waitCycles(3);
        checkOutput("t4_zero_held", audio_left, 16'h0);
        checkOutput("t4_zero_gnt", 16'(gnt), 16'h1);

        $display("[TB] owner drops, gap then idle");
        applyStimulus(3'b000);
        waitCycles(1);
        checkOutput("gap_gnt",   16'(gnt), 16'h0);
        checkOutput("gap_busy",  16'(busy), 16'h1);
        checkOutput("gap_audio", audio_left, 16'h0);
        waitCycles(3);
        checkOutput("gap_last_busy", 16'(busy), 16'h1);
        waitCycles(1);
        checkOutput("idle_busy", 16'(busy), 16'h0);
        checkOutput("idle_gnt2", 16'(gnt), 16'h0);

        $display("[TB] pre-emption by req0");
        setDiv(2, 22'd2);
        applyStimulus(3'b100);
        waitCycles(1);
        checkOutput("t2_gnt",   16'(gnt), 16'h4);
        checkOutput("t2_first", audio_left, POS);
        waitCycles(2);
        checkOutput("t2_low",   audio_left, NEG);
        setDiv(0, 22'd5);
        applyStimulus(3'b101);
        waitCycles(1);
        checkOutput("t2_gap_gnt",   16'(gnt), 16'h0);
        checkOutput("t2_gap_audio", audio_left, 16'h0);
        waitCycles(3);
        checkOutput("t2_gap_end_gnt", 16'(gnt), 16'h0);
        checkOutput("t2_gap_end_audio", audio_left, 16'h0);
        waitCycles(1);
        checkOutput("t2_new_gnt",   16'(gnt), 16'h1);
        checkOutput("t2_new_first", audio_left, POS);

        $display("[TB] lower priority ignored, then handover");
        setDiv(1, 22'd1);
        applyStimulus(3'b011);
        waitCycles(1);
        checkOutput("t3_keep_gnt", 16'(gnt), 16'h1);
        applyStimulus(3'b010);
        waitCycles(1);
        checkOutput("t3_gap_gnt", 16'(gnt), 16'h0);
        waitCycles(3);
        checkOutput("t3_gap_end_gnt", 16'(gnt), 16'h0);
        waitCycles(1);
        checkOutput("t3_new_gnt",   16'(gnt), 16'h2);
        checkOutput("t3_new_first", audio_left, POS);
        waitCycles(1);
        checkOutput("t3_div1_toggle", audio_left, NEG);

        $display("[TB] mute while playing");
        mute = 1'b1;
        waitCycles(1);
        checkOutput("t5_muted", audio_left, 16'h0);
        waitCycles(1);
        checkOutput("t5_muted2", audio_right, 16'h0);
        checkOutput("t5_gnt",    16'(gnt), 16'h2);
        mute = 1'b0;
        waitCycles(1);
        checkOutput("t5_resume", audio_left, POS);
        waitCycles(1);
        checkOutput("t5_resume2", audio_left, NEG);

        $display("[TB] async reset mid-play");
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6_gnt",   16'(gnt), 16'h0);
        checkOutput("t6_busy",  16'(busy), 16'h0);
        checkOutput("t6_left",  audio_left, 16'h0);
        checkOutput("t6_right", audio_right, 16'h0);
        setDiv(2, 22'd2);
        applyStimulus(3'b100);
        waitCycles(1);
        checkOutput("t6_held_gnt", 16'(gnt), 16'h0);
        rst_n = 1'b1;
        waitCycles(1);
        checkOutput("t6_new_gnt",   16'(gnt), 16'h4);
        checkOutput("t6_new_first", audio_left, POS);
        waitCycles(2);
        checkOutput("t6_new_low", audio_left, NEG);

        $display("[TB] owner drop and higher rise together");
        applyStimulus(3'b010);
        waitCycles(1);
        checkOutput("sim_gap_gnt", 16'(gnt), 16'h0);
        waitCycles(3);
        checkOutput("sim_gap_end_gnt",  16'(gnt), 16'h0);
        checkOutput("sim_gap_end_busy", 16'(busy), 16'h1);
        waitCycles(1);
        checkOutput("sim_new_gnt",   16'(gnt), 16'h2);
        checkOutput("sim_new_first", audio_left, POS);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
